// File: rtl/bit_packer.sv
// bit_packer: packs a valid/ready single-bit stream into WIDTH-bit words.
// A completed word is held on a valid/ready output together with its count of
// ones, while packing of the next word continues underneath it.
// Optional feature macro: BIT_PACKER_PARITY_EN adds a registered out_parity
// output (XOR of out_word).
module bit_packer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [CW-1:0]    out_ones
`ifdef BIT_PACKER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int unsigned PW = $clog2(WIDTH);
  localparam logic [PW-1:0] LastIdx = PW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic [CW-1:0]    out_ones_q, out_ones_d;
`ifdef BIT_PACKER_PARITY_EN
  logic             out_parity_q, out_parity_d;
`endif

  logic          last;
  logic          accept;
  logic          take;
  logic [PW-1:0] idx;

  // Handshake decode; only the word-completing bit can stall on an untaken word.
  always_comb begin
    last     = (cnt_q == LastIdx);
    in_ready = rst_n && !(last && out_valid_q && !out_ready);
    accept   = in_valid && in_ready;
    take     = out_valid_q && out_ready;
    idx      = (MSB_FIRST != 0) ? (LastIdx - cnt_q) : cnt_q;
  end

  // Next-state: fill the shift register, and hand the word over on completion.
  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_ones_d  = out_ones_q;
`ifdef BIT_PACKER_PARITY_EN
    out_parity_d = out_parity_q;
`endif
    if (take) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      sr_d[idx] = in_bit;
      if (last) begin
        // A completing load wins over a same-cycle take: no bubble.
        cnt_d       = '0;
        ones_d      = '0;
        out_valid_d = 1'b1;
        out_word_d  = sr_d;
        out_ones_d  = ones_q + CW'(in_bit);
`ifdef BIT_PACKER_PARITY_EN
        out_parity_d = ^sr_d;
`endif
      end else begin
        cnt_d  = cnt_q + PW'(1);
        ones_d = ones_q + CW'(in_bit);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      ones_q      <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_ones_q  <= '0;
`ifdef BIT_PACKER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_ones_q  <= out_ones_d;
`ifdef BIT_PACKER_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  // Output drive from registered state.
  always_comb begin
    out_valid = out_valid_q;
    out_word  = out_word_q;
    out_ones  = out_ones_q;
`ifdef BIT_PACKER_PARITY_EN
    out_parity = out_parity_q;
`endif
  end

endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: directed, table-driven bench for bit_packer (WIDTH=8).
// Two instances share the stimulus: LSB-first and MSB-first placement.
module tb_bit_packer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       rdy_l, rdy_m;
  logic       ov_l, ov_m;
  logic [7:0] word_l, word_m;
  logic [3:0] ones_l, ones_m;
`ifdef BIT_PACKER_PARITY_EN
  logic       par_l, par_m;
`endif

  int total;
  int bad;

  bit_packer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (rdy_l),
    .out_valid(ov_l),
    .out_ready(out_ready),
    .out_word (word_l),
    .out_ones (ones_l)
`ifdef BIT_PACKER_PARITY_EN
    ,
    .out_parity(par_l)
`endif
  );

  bit_packer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (rdy_m),
    .out_valid(ov_m),
    .out_ready(out_ready),
    .out_word (word_m),
    .out_ones (ones_m)
`ifdef BIT_PACKER_PARITY_EN
    ,
    .out_parity(par_m)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rn, v, b, r;
    logic       exp_rdy, exp_ov;
    logic [7:0] exp_wl, exp_wm;
    logic [3:0] exp_ones;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rn, v, b, r, exp_rdy, exp_ov,
                     input logic [7:0] wl, wm, input logic [3:0] ones);
    vec_t e;
    e.rn = rn; e.v = v; e.b = b; e.r = r;
    e.exp_rdy = exp_rdy; e.exp_ov = exp_ov;
    e.exp_wl = wl; e.exp_wm = wm; e.exp_ones = ones;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // One cycle: drive after the falling edge, check ready before the rising
  // edge, check registered outputs just after it.
  task automatic apply(input vec_t e, input string nm);
    @(negedge clk);
    rst_n = e.rn; in_valid = e.v; in_bit = e.b; out_ready = e.r;
    #1;
    chk({nm, " in_ready_lsb"}, 32'(rdy_l), 32'(e.exp_rdy));
    chk({nm, " in_ready_msb"}, 32'(rdy_m), 32'(e.exp_rdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(ov_l), 32'(e.exp_ov));
    chk({nm, " out_valid_msb"}, 32'(ov_m), 32'(e.exp_ov));
    chk({nm, " word_lsb"}, 32'(word_l), 32'(e.exp_wl));
    chk({nm, " word_msb"}, 32'(word_m), 32'(e.exp_wm));
    chk({nm, " ones"}, 32'(ones_l), 32'(e.exp_ones));
`ifdef BIT_PACKER_PARITY_EN
    chk({nm, " parity_lsb"}, 32'(par_l), 32'(^e.exp_wl));
    chk({nm, " parity_msb"}, 32'(par_m), 32'(^e.exp_wm));
`endif
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] words[3];
    logic [7:0] prev_w;
    logic [3:0] prev_o;
    vec_t       e;

    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;

    // Reset.
    add(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 4'd0);
    add(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 4'd0);
    // Basic word 1,0,1,1,0,0,0,1 with out_ready=1 -> 8D / B1 / 4.
    pat = 8'b1000_1101;
    for (int i = 0; i < 7; i++) add(1, 1, pat[i], 1, 1, 0, 8'h00, 8'h00, 4'd0);
    add(1, 1, 1, 1, 1, 1, 8'h8D, 8'hB1, 4'd4);
    add(1, 0, 0, 1, 1, 0, 8'h8D, 8'hB1, 4'd4);
    // Back-pressure: eight 1s held as FF/8, then 8D pattern stalls on its last bit.
    for (int i = 0; i < 7; i++) add(1, 1, 1, 0, 1, 0, 8'h8D, 8'hB1, 4'd4);
    add(1, 1, 1, 0, 1, 1, 8'hFF, 8'hFF, 4'd8);
    for (int i = 0; i < 7; i++) add(1, 1, pat[i], 0, 1, 1, 8'hFF, 8'hFF, 4'd8);
    add(1, 1, 1, 0, 0, 1, 8'hFF, 8'hFF, 4'd8);
    add(1, 1, 1, 0, 0, 1, 8'hFF, 8'hFF, 4'd8);
    add(1, 1, 1, 1, 1, 1, 8'h8D, 8'hB1, 4'd4);
    add(1, 0, 0, 1, 1, 0, 8'h8D, 8'hB1, 4'd4);
    // in_valid toggling with garbage on idle cycles: valid bits 1,0,0,1,1,1,0,1.
    pat = 8'b1011_1001;
    for (int i = 0; i < 7; i++) begin
      add(1, 1, pat[i], 1, 1, 0, 8'h8D, 8'hB1, 4'd4);
      add(1, 0, ~pat[i], 1, 1, 0, 8'h8D, 8'hB1, 4'd4);
    end
    add(1, 1, 1, 1, 1, 1, 8'hB9, 8'h9D, 4'd5);
    add(1, 0, 0, 1, 1, 0, 8'hB9, 8'h9D, 4'd5);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // Continuous stream, out_ready=1 every cycle: one word per 8 cycles.
    words[0] = 8'hA5; words[1] = 8'h37; words[2] = 8'hFE;
    prev_w = 8'hB9; prev_o = 4'd5;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) begin
        e.rn = 1; e.v = 1; e.b = words[w][i]; e.r = 1; e.exp_rdy = 1;
        if (i == 7) begin
          prev_w = words[w];
          prev_o = 4'($countones(words[w]));
        end
        e.exp_ov = (i == 7);
        e.exp_wl = prev_w; e.exp_wm = (w == 0 && i < 7) ? 8'h9D : rev8(prev_w);
        e.exp_ones = prev_o;
        apply(e, $sformatf("stream w%0d b%0d", w, i));
      end
    end

    // Reset while a word is pending and another is partly filled.
    e.rn = 1; e.v = 0; e.b = 0; e.r = 1; e.exp_rdy = 1; e.exp_ov = 0;
    e.exp_wl = 8'hFE; e.exp_wm = 8'h7F; e.exp_ones = 4'd7;
    apply(e, "pre-reset take");
    for (int i = 0; i < 13; i++) begin
      e.v = 1; e.b = 1; e.r = 0; e.exp_rdy = 1; e.exp_ov = (i >= 7);
      e.exp_wl = (i >= 7) ? 8'hFF : 8'hFE; e.exp_wm = (i >= 7) ? 8'hFF : 8'h7F;
      e.exp_ones = (i >= 7) ? 4'd8 : 4'd7;
      apply(e, $sformatf("pending b%0d", i));
    end
    e.rn = 0; e.v = 1; e.b = 1; e.r = 0; e.exp_rdy = 0; e.exp_ov = 0;
    e.exp_wl = 8'h00; e.exp_wm = 8'h00; e.exp_ones = 4'd0;
    apply(e, "mid-word reset");
    for (int i = 0; i < 8; i++) begin
      e.rn = 1; e.v = 1; e.b = 0; e.r = 0; e.exp_rdy = 1; e.exp_ov = (i == 7);
      apply(e, $sformatf("post-reset zero b%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_packer.md
# bit_packer

Downstream collector for the single-bit result stream produced by the 3-input adder stage (its registered `out`). Each valid bit is packed into a WIDTH-bit word. Completed words are presented on a valid/ready output with a running count of ones. Packing of the next word continues while the previous word waits, so one full word of buffering decouples the bit stream from the word consumer.

## Interface
- `WIDTH`, 8: bits per packed word; legal range 2..32.
- `MSB_FIRST`, 0: 0 places the first accepted bit at word bit 0; 1 places it at word bit WIDTH-1.
- `CW`, derived `$clog2(WIDTH+1)`: width of the ones count; not overridden.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  `in_bit` carries a sample this cycle.
- `in_bit`  in  1  sample value, normally the adder stage's `out`.
- `in_ready`  out  1  packer accepts a sample this cycle.
- `out_valid`  out  1  `out_word`/`out_ones` hold a completed word.
- `out_ready`  in  1  consumer takes the word this cycle.
- `out_word`  out  WIDTH  packed word.
- `out_ones`  out  CW  number of 1 bits in `out_word`.

## Operation
- Accept = `in_valid && in_ready`. Take = `out_valid && out_ready`.
- Fill state: shift register `sr` (WIDTH), position counter `cnt` (0..WIDTH-1), partial ones counter `ones` (CW).
- On accept:
  - Write `in_bit` into `sr` at index `cnt` (MSB_FIRST=0) or index `WIDTH-1-cnt` (MSB_FIRST=1).
  - Increment `ones` by `in_bit`.
  - Increment `cnt`.
- Completing accept (accept while `cnt==WIDTH-1`):
  - Load `out_word` with `sr` including the current bit.
  - Load `out_ones` with `ones + in_bit`.
  - Set `out_valid`; clear `cnt` and `ones`. `sr` need not clear; stale bits are overwritten before reuse.
- Take without a completing accept: clear `out_valid`.
- Take and completing accept in the same cycle: the new word is loaded and `out_valid` stays 1. No bubble, no loss.
- `in_ready = rst_n && !(cnt==WIDTH-1 && out_valid && !out_ready)`.
  - A stall occurs only when the last bit of a word would overwrite an untaken word.
  - `in_ready` may depend combinationally on `out_ready`. It never depends on `in_valid`.
- Holding rule: `out_word` and `out_ones` change only on a completing accept. While `out_valid && !out_ready` they stay stable.
- `in_bit` is ignored when `in_valid` is 0.
- Overflow: `ones` never exceeds WIDTH, so CW bits suffice. No modular wrap.

## Timing
- Reset (`rst_n` low at a rising edge): `out_valid`=0, `out_word`=0, `out_ones`=0, `cnt`=0, `ones`=0. `in_ready`=0 while `rst_n` is low and 1 in the first cycle after release.
- Reset mid-word discards partial bits. Reset with `out_valid` high drops the pending word, and nothing is emitted after release.
- Latency: `out_valid` rises in the cycle after the edge that accepts the WIDTH-th bit.
- Throughput: one bit per cycle sustained when the consumer takes each word within WIDTH-1 cycles of it appearing.
- Back-pressure: the completing bit stalls (`in_ready`=0) until the cycle `out_ready` is 1. It is then accepted in that same cycle.

## Configuration
- `BIT_PACKER_PARITY_EN`:
  - Defined: adds output `out_parity` (1 bit) = XOR of `out_word`. It is registered and loaded with `out_word`, resets to 0, and obeys the same holding rule.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, MSB_FIRST=0, `out_ready`=1, bits 1,0,1,1,0,0,0,1 on consecutive cycles -> next cycle `out_valid`=1, `out_word`=8'h8D, `out_ones`=4. `out_parity`=0 when enabled.
- Same stimulus with MSB_FIRST=1 -> `out_word`=8'hB1, `out_ones`=4.
- `out_ready`=0, 16 bits streamed (all 1s, then 8'h8D pattern):
  - First word 8'hFF/8 is held.
  - `in_ready` drops at the 16th bit.
  - Raising `out_ready` for one cycle accepts that bit. The next cycle shows 8'h8D/4, with no gap in `out_valid`.
- Continuous stream with `out_ready`=1 every cycle -> one word every 8 cycles, `in_ready` never drops, and take/load collide without loss.
- `rst_n` low for 1 cycle after 5 accepted bits, then 8 bits all 0 -> `out_word`=8'h00, `out_ones`=0. No residue from the aborted word.
- `in_valid` toggling 1,0 with `in_bit` garbage on idle cycles -> the word reflects only the valid samples.
